// File: rtl/fir_pkg.sv
// Shared FIR constants: default sample widths, the Q15 shift and the
// 16-bit saturation limits used by the filter blocks.
package fir_pkg;
  localparam int FIR_IN_BIT_NUM   = 32;
  localparam int FIR_DATA_BIT_NUM = 16;
  localparam int FIR_SHIFT        = 15;

  localparam logic signed [FIR_DATA_BIT_NUM-1:0] FIR_SAT_MAX = 16'sh7FFF;
  localparam logic signed [FIR_DATA_BIT_NUM-1:0] FIR_SAT_MIN = 16'sh8000;
endpackage

// File: rtl/fir_out_fifo.sv
// Output FIFO for requantized samples. Storage array plus a registered
// head slot. A write lands in the array and reaches the head one edge later.
// The head slot and the array entries together form 'count'. 'empty' means
// nothing is readable at the head. The caller guarantees count never
// exceeds DEPTH.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FIR_DATA_BIT_NUM,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] mem_cnt_q, mem_cnt_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          dout_vld_q, dout_vld_d;
  logic          pop, load;

  // Next state: array write, head refill when free or being popped.
  // Pointers are power-of-two wide, so they wrap modulo DEPTH.
  always_comb begin
    pop        = dout_vld_q & rd_en;
    load       = (mem_cnt_q != '0) & (~dout_vld_q | pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (load) begin
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    mem_cnt_d  = mem_cnt_q + CW'(wr_en) - CW'(load);
    dout_vld_d = load | (dout_vld_q & ~pop);
  end

  // State registers; reset empties the FIFO and clears the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign rd_data = dout_q;
  assign empty   = ~dout_vld_q;
  assign count   = mem_cnt_q + CW'(dout_vld_q);
  assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantizer: sign-extend, optionally round, arithmetic shift,
// and saturate to DATA_BIT_NUM. The result is held in stage S1 and then
// buffered in fir_out_fifo. Ready/valid on both sides.
// Macro FIR_OUT_ROUND_EN: round half up before the shift (default: truncate).
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int IN_BIT_NUM   = FIR_IN_BIT_NUM,
  parameter int DATA_BIT_NUM = FIR_DATA_BIT_NUM,
  parameter int SHIFT        = FIR_SHIFT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [IN_BIT_NUM-1:0]   in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [DATA_BIT_NUM-1:0] out_data,
  input  logic                    out_ready,
  output logic [15:0]             sat_cnt,
  output logic [15:0]             drop_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = IN_BIT_NUM - DATA_BIT_NUM + 2;
  localparam logic signed [IN_BIT_NUM:0] LIM_HI = {{PW{1'b0}}, {(DATA_BIT_NUM-1){1'b1}}};
  localparam logic signed [IN_BIT_NUM:0] LIM_LO = {{PW{1'b1}}, {(DATA_BIT_NUM-1){1'b0}}};
`ifdef FIR_OUT_ROUND_EN
  localparam logic signed [IN_BIT_NUM:0] RND = (IN_BIT_NUM+1)'(1) << (SHIFT-1);
`endif

  logic signed [IN_BIT_NUM:0] ext, sh;
  logic                       sat_hi, sat_lo, acc, pop, at_cap;
  logic [DATA_BIT_NUM-1:0]    q_val;
  logic                       s1_vld_q, s1_vld_d;
  logic [DATA_BIT_NUM-1:0]    s1_data_q, s1_data_d;
  logic [15:0]                sat_cnt_q, sat_cnt_d, drop_cnt_q, drop_cnt_d;
  logic                       rdy_en_q, rdy_en_d;
  logic                       fifo_empty, fifo_full;
  logic [CW-1:0]              fifo_cnt;

  // Requantize in IN_BIT_NUM+1 bits so the rounding add cannot overflow.
  always_comb begin
    ext = {in_data[IN_BIT_NUM-1], in_data};
`ifdef FIR_OUT_ROUND_EN
    ext = ext + RND;
`endif
    sh     = ext >>> SHIFT;
    sat_hi = sh > LIM_HI;
    sat_lo = sh < LIM_LO;
    if (sat_hi)      q_val = {1'b0, {(DATA_BIT_NUM-1){1'b1}}};
    else if (sat_lo) q_val = {1'b1, {(DATA_BIT_NUM-1){1'b0}}};
    else             q_val = sh[DATA_BIT_NUM-1:0];
  end

  // Handshake and counters. Occupancy (FIFO + S1) is capped at FIFO_DEPTH,
  // with a same-cycle pop freeing a slot. rdy_en_q holds ready low until the
  // first edge after reset release.
  always_comb begin
    pop        = out_valid & out_ready;
    at_cap     = fifo_full | (s1_vld_q & (fifo_cnt == CW'(FIFO_DEPTH-1)));
    in_ready   = rdy_en_q & (~at_cap | pop);
    acc        = in_valid & in_ready;
    s1_vld_d   = acc;
    s1_data_d  = acc ? q_val : s1_data_q;
    rdy_en_d   = 1'b1;
    sat_cnt_d  = sat_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (acc && (sat_hi || sat_lo) && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
    if (in_valid && !in_ready && drop_cnt_q != 16'hFFFF)    drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // S1 stage, counters and ready enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      sat_cnt_q  <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

  fir_out_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BIT_NUM)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s1_vld_q),
    .wr_data (s1_data_q),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_cnt)
  );

  assign out_valid = ~fifo_empty;
  assign sat_cnt   = sat_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: reset, latency, requant vectors
// (truncate or FIR_OUT_ROUND_EN build), backpressure, full-FIFO streaming,
// mid-stream reset.
module tb_fir_out_requant;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic [15:0] sat_cnt, drop_cnt;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fir_out_requant #(.IN_BIT_NUM(32), .DATA_BIT_NUM(16), .SHIFT(15), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sat_cnt(sat_cnt), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One sample through an empty block with out_ready=1: visible after edge N+2.
  task automatic one(input string tag, input logic [31:0] d, input logic [15:0] exp);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    step;                          // edge N: accept
    in_valid = 1'b0;
    step;                          // edge N+1
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    step;                          // edge N+2
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_dat"}, 32'(out_data), 32'(exp));
    step;                          // popped
    chk({tag, "_gone"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_dat", 32'(out_data), 32'd0);
    chk("rst_sat", 32'(sat_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_rdy_lo", 32'(in_ready), 32'd0);
    step;
    chk("rel_rdy_hi", 32'(in_ready), 32'd1);

    // Requant vectors
    out_ready = 1'b1;
`ifdef FIR_OUT_ROUND_EN
    one("rnd_half", 32'h0000_4000, 16'h0001);
    one("rnd_neg",  32'hFFFF_C000, 16'h0000);
    one("rnd_max",  32'h7FFF_FFFF, 16'h7FFF);
    chk("rnd_sat1", 32'(sat_cnt), 32'd1);
    one("sat_pos",  32'h4000_0000, 16'h7FFF);
    one("sat_min",  32'hC000_0000, 16'h8000);
    one("sat_neg",  32'hBFFF_8000, 16'h8000);
    chk("sat_cnt", 32'(sat_cnt), 32'd3);
`else
    one("trc_one", 32'h0000_8000, 16'h0001);
    one("trc_neg", 32'hFFFF_C000, 16'hFFFF);
    chk("trc_sat0", 32'(sat_cnt), 32'd0);
    one("sat_pos", 32'h4000_0000, 16'h7FFF);
    one("sat_min", 32'hC000_0000, 16'h8000);
    one("sat_neg", 32'hBFFF_8000, 16'h8000);
    chk("sat_cnt", 32'(sat_cnt), 32'd2);
`endif
    chk("drop0", 32'(drop_cnt), 32'd0);

    // Backpressure: ramp 1..6, only 4 fit
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i) << 15;
      chk($sformatf("bp_rdy%0d", i), 32'(in_ready), (i <= 4) ? 32'd1 : 32'd0);
      step;
    end
    in_valid = 1'b0;
    chk("bp_drop", 32'(drop_cnt), 32'd2);
    step;
    chk("bp_full_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_vld", 32'(out_valid), 32'd1);
    chk("bp_hold_dat", 32'(out_data), 32'd1);
    step;
    chk("bp_hold_dat2", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #0;
      chk($sformatf("bp_out%0d", i), 32'(out_data), 32'(i));
      step;
    end
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Simultaneous accept/pop on a full FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(10 + i) << 15;
      step;
    end
    in_valid = 1'b0;
    repeat (3) step;
    chk("sim_full_rdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(14 + k) << 15;
      #0;
      chk($sformatf("sim_rdy%0d", k), 32'(in_ready), 32'd1);
      chk($sformatf("sim_dat%0d", k), 32'(out_data), 32'(10 + k));
      step;
    end
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("sim_drain%0d", j), {15'd0, out_valid, out_data}, {16'd1, 16'(30 + j)});
      step;
    end
    chk("sim_empty", 32'(out_valid), 32'd0);
    chk("sim_drop", 32'(drop_cnt), 32'd2);

    // Mid-stream reset with 3 samples buffered
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i) << 15;
      step;
    end
    in_valid = 1'b0;
    step;
    chk("mr_pre_vld", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_vld", 32'(out_valid), 32'd0);
    chk("mr_sat", 32'(sat_cnt), 32'd0);
    chk("mr_drop", 32'(drop_cnt), 32'd0);
    step;
    rst = 1'b0;
    #1;
    chk("mr_rdy_lo", 32'(in_ready), 32'd0);
    step;
    chk("mr_rdy_hi", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("mr_stale%0d", j), 32'(out_valid), 32'd0);
      step;
    end
    one("mr_new", 32'h0002_8000, 16'h0005);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fir_out_requant.md
FIR_OUT_REQUANT -- requirements
Module: fir_out_requant

Interface
REQ-001 SHALL have parameter IN_BIT_NUM, default 32, the width of the signed filter output sample consumed.
REQ-002 SHALL have parameter DATA_BIT_NUM, default 16, the width of the signed requantized sample produced.
REQ-003 SHALL have parameter SHIFT, default 15, the arithmetic right-shift applied (Q15 coefficient scaling); legal range 1..IN_BIT_NUM-DATA_BIT_NUM+1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, the output buffer entries; power of two, >=2.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; asynchronous assert, active-high.
REQ-007 in_valid  input  1  filter output sample present.
REQ-008 in_data  input  IN_BIT_NUM  signed filter output sample.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data holds a valid sample.
REQ-011 out_data  output  DATA_BIT_NUM  signed requantized sample.
REQ-012 out_ready  input  1  downstream consumes out_data this cycle.
REQ-013 sat_cnt  output  16  count of saturated samples, sticks at 0xFFFF.
REQ-014 drop_cnt  output  16  count of cycles with in_valid=1 and in_ready=0, sticks at 0xFFFF.

Function
REQ-015 Accept SHALL occur when in_valid and in_ready are both 1 at a rising edge; pop SHALL occur when out_valid and out_ready are both 1.
REQ-016 Accepted samples SHALL pass through one pipeline register (stage S1) and then into the FIFO; occupancy = FIFO entries + S1 valid.
REQ-017 in_ready SHALL be 1 exactly when occupancy < FIFO_DEPTH, or occupancy = FIFO_DEPTH with a pop in the same cycle.
REQ-018 S1 SHALL compute in IN_BIT_NUM+1 bits: sign-extend, optional rounding add (REQ-029), arithmetic shift right by SHIFT, so no intermediate overflow occurs.
REQ-019 Shifted results above 2^(DATA_BIT_NUM-1)-1 SHALL clamp to 0x7FFF, below -2^(DATA_BIT_NUM-1) to 0x8000, and each clamp SHALL increment sat_cnt once.
REQ-020 Latency SHALL be 2 cycles: sample accepted at edge N is visible at out_data with out_valid=1 after edge N+2 when the FIFO was empty.
REQ-021 FIFO SHALL deliver samples in acceptance order; no sample is lost or duplicated when accept and pop coincide, including when full and when empty.
REQ-022 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 drop_cnt SHALL increment on every cycle where in_valid=1 and in_ready=0; the sample is discarded.

Reset
REQ-025 While rst=1: out_valid=0, out_data=0, in_ready=0, sat_cnt=0, drop_cnt=0, S1 cleared, FIFO emptied.
REQ-026 rst asserted mid-stream SHALL discard all buffered and in-flight samples immediately; no output appears after deassertion until a new accept.
REQ-027 in_ready SHALL rise on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro FIR_OUT_ROUND_EN SHALL select rounding mode.
REQ-029 With FIR_OUT_ROUND_EN defined, S1 SHALL add 2^(SHIFT-1) before the shift (round half up); without it, S1 SHALL truncate (floor toward minus infinity).

Structure
REQ-030 Shared package fir_pkg SHALL hold DATA_BIT_NUM, IN_BIT_NUM, SHIFT defaults and the saturation limit constants, shared with the FIR filter blocks.
REQ-031 FIFO SHALL be sub-module fir_out_fifo (synchronous, FIFO_DEPTH x DATA_BIT_NUM, full/empty/count outputs).

Verification
REQ-032 Truncate build: in_data=0x00008000 -> out_data=0x0001; in_data=0xFFFFC000 -> out_data=0xFFFF; sat_cnt=0.
REQ-033 Round build: in_data=0x00004000 -> 0x0001; in_data=0xFFFFC000 -> 0x0000; in_data=0x7FFFFFFF -> 0x7FFF, sat_cnt=1.
REQ-034 Saturation: 0x40000000 -> 0x7FFF, 0xC0000000 -> 0x8000 (no sat), 0xBFFF8000 -> 0x8000; sat_cnt=2 in truncate build.
REQ-035 Backpressure: out_ready=0, in_valid=1 for 6 cycles with ramp 1..6 (<<15) -> 4 accepted, in_ready=0 thereafter, drop_cnt=2; release out_ready -> outputs 1,2,3,4 in order.
REQ-036 Simultaneous: full FIFO, out_ready=1 and in_valid=1 continuously for 20 cycles -> one accept and one pop per cycle, order preserved, drop_cnt unchanged.
REQ-037 Reset mid-stream: rst=1 for 1 cycle with 3 samples buffered -> out_valid=0 immediately, counters 0, in_ready=1 one edge after release, no stale sample emitted.
